gcd_iter: RTL and testbench
===========================

GCD_ITER -- requirements
Module: gcd_iter

Interface
REQ-001 Parameter WL, default 8, operand and result width in bits (WL >= 2).
REQ-002 Parameter CW, default 16, width of the cycle-count output.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_b  input  1  reset, asynchronous, active-low.
REQ-005 ops_val  input  1  operand request valid.
REQ-006 ops_rdy  output  1  block accepts operands.
REQ-007 op_a  input  WL  operand A, unsigned.
REQ-008 op_b  input  WL  operand B, unsigned.
REQ-009 mode  input  1  algorithm select: 0 = subtractive Euclid, 1 = binary (Stein).
REQ-010 res_val  output  1  result valid.
REQ-011 res_rdy  input  1  consumer accepts result.
REQ-012 res  output  WL  gcd(A,B).
REQ-013 res_cycles  output  CW  number of CALC cycles used for this result.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, CALC and DONE; ops_rdy = (state==IDLE), res_val = (state==DONE), busy = (state!=IDLE).
REQ-016 An operand handshake SHALL occur on a rising edge with ops_val && ops_rdy; it captures op_a->A, op_b->B and mode, clears the counter and shift count K, and moves to CALC.
REQ-017 Operand inputs SHALL be ignored outside a handshake; changes after capture have no effect.
REQ-018 In CALC, the counter SHALL increment once per cycle, including the terminating cycle, and saturate at 2^CW-1.
REQ-019 Euclid mode SHALL perform exactly one action per CALC cycle, in priority order: B==0 -> res=A, go DONE; A<B -> swap A,B; else A=A-B.
REQ-020 Binary mode SHALL perform exactly one action per CALC cycle, in priority order: A==0 -> res=B<<K, DONE; B==0 -> res=A<<K, DONE; both even -> A>>=1, B>>=1, K++; A even -> A>>=1; B even -> B>>=1; A>=B -> A=A-B; else B=B-A.
REQ-021 K SHALL be wide enough to hold WL; the shifted result SHALL never exceed WL bits.
REQ-022 gcd(0,0) SHALL return 0 in both modes.
REQ-023 On entering DONE, res and res_cycles SHALL be registered and held stable until the result handshake.
REQ-024 The result handshake (res_val && res_rdy on a rising edge) SHALL move the FSM to IDLE; ops_rdy rises in the following cycle, with no overlap between operations.
REQ-025 res and res_cycles SHALL retain the last result while in IDLE and CALC.
REQ-026 Latency SHALL be 1 cycle (capture) + res_cycles (CALC) before res_val is asserted.

Reset
REQ-027 While rst_b=0, regardless of the clock: state=IDLE, A=B=0, K=0, counter=0, res=0, res_cycles=0; outputs res_val=0, busy=0, ops_rdy=1.
REQ-028 Reset asserted mid-CALC or mid-DONE SHALL abort the operation without emitting a result; the first cycle after release SHALL be IDLE.

Verification
REQ-029 WL=8, mode=0, A=6, B=4 -> res=2, res_cycles=6, res_val asserted 7 cycles after capture.
REQ-030 WL=8, mode=1, A=6, B=4 -> res=2, res_cycles=6; A=0, B=0 in either mode -> res=0, res_cycles=1.
REQ-031 mode=0, A=0, B=5 -> res=5, res_cycles=2; mode=1, A=0, B=5 -> res=5, res_cycles=1.
REQ-032 Backpressure: res_rdy held low for 5 cycles in DONE -> res_val stays 1, res/res_cycles stable, ops_rdy stays 0, ops_val ignored.
REQ-033 Reset pulse during CALC of A=200, B=3 -> all outputs at reset values; a following A=12, B=18 (mode 1) -> res=6.
REQ-034 WL=16 random sweep in both modes against a reference model: res equals gcd(A,B); both modes yield identical res for identical operands.

Source files
------------

// File: rtl/gcd_iter.sv
// Iterative GCD engine: subtractive Euclid or binary (Stein) algorithm, one step per clock,
// with valid/ready handshakes on the operand and result sides and a saturating cycle counter.
module gcd_iter #(
    parameter int WL = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          ops_val,
    output logic          ops_rdy,
    input  logic [WL-1:0] op_a,
    input  logic [WL-1:0] op_b,
    input  logic          mode,
    output logic          res_val,
    input  logic          res_rdy,
    output logic [WL-1:0] res,
    output logic [CW-1:0] res_cycles,
    output logic          busy
);

    // K counts common factors of two; it can never exceed WL-1 but is sized to hold WL.
    localparam int KW = $clog2(WL + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [WL-1:0]   r_a;
    logic [WL-1:0]   r_b;
    logic [KW-1:0]   r_k;
    logic [CW-1:0]   r_cnt;
    logic            r_mode;
    logic [WL-1:0]   r_res;
    logic [CW-1:0]   r_res_cycles;

    logic [WL-1:0]   w_a_next;
    logic [WL-1:0]   w_b_next;
    logic [KW-1:0]   w_k_next;
    logic [CW-1:0]   w_cnt_inc;
    logic [WL-1:0]   w_res_calc;
    logic            w_finish;
    logic            w_ops_fire;
    logic            w_res_fire;

    assign w_ops_fire = ops_val && ops_rdy;
    assign w_res_fire = res_val && res_rdy;
    assign w_cnt_inc  = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);

    // One algorithm step, evaluated every cycle; only committed while in CALC.
    always_comb begin
        w_a_next   = r_a;
        w_b_next   = r_b;
        w_k_next   = r_k;
        w_res_calc = r_res;
        w_finish   = 1'b0;
        if (!r_mode) begin
            if (r_b == '0) begin
                w_finish   = 1'b1;
                w_res_calc = r_a;
            end else if (r_a < r_b) begin
                w_a_next = r_b;
                w_b_next = r_a;
            end else begin
                w_a_next = r_a - r_b;
            end
        end else begin
            if (r_a == '0) begin
                w_finish   = 1'b1;
                w_res_calc = r_b << r_k;
            end else if (r_b == '0) begin
                w_finish   = 1'b1;
                w_res_calc = r_a << r_k;
            end else if (!r_a[0] && !r_b[0]) begin
                w_a_next = r_a >> 1;
                w_b_next = r_b >> 1;
                w_k_next = r_k + KW'(1);
            end else if (!r_a[0]) begin
                w_a_next = r_a >> 1;
            end else if (!r_b[0]) begin
                w_b_next = r_b >> 1;
            end else if (r_a >= r_b) begin
                w_a_next = r_a - r_b;
            end else begin
                w_b_next = r_b - r_a;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_ops_fire) w_state_next = S_CALC;
            S_CALC:  if (w_finish)   w_state_next = S_DONE;
            S_DONE:  if (w_res_fire) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ops_rdy = (r_state == S_IDLE);
        res_val = (r_state == S_DONE);
        busy    = (r_state != S_IDLE);
    end

    // Operands latch only on the handshake; the result pair latches only on the finishing step.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_a          <= '0;
            r_b          <= '0;
            r_k          <= '0;
            r_cnt        <= '0;
            r_mode       <= 1'b0;
            r_res        <= '0;
            r_res_cycles <= '0;
        end else if (w_ops_fire) begin
            r_a    <= op_a;
            r_b    <= op_b;
            r_mode <= mode;
            r_k    <= '0;
            r_cnt  <= '0;
        end else if (r_state == S_CALC) begin
            r_a   <= w_a_next;
            r_b   <= w_b_next;
            r_k   <= w_k_next;
            r_cnt <= w_cnt_inc;
            if (w_finish) begin
                r_res        <= w_res_calc;
                r_res_cycles <= w_cnt_inc;
            end
        end
    end

    assign res        = r_res;
    assign res_cycles = r_res_cycles;

endmodule

// File: tb/tb_gcd_iter.sv
// Directed and random checks of gcd_iter in an 8-bit and a 16-bit instance.
module tb_gcd_iter;

    logic        clk;
    logic        rst_b;
    logic        use16;
    logic        ops_val;
    logic        res_rdy;
    logic        mode_s;
    logic [15:0] op_a;
    logic [15:0] op_b;

    logic        ops_val8, ops_val16, res_rdy8, res_rdy16;
    logic        ops_rdy8, res_val8, busy8;
    logic        ops_rdy16, res_val16, busy16;
    logic [7:0]  res8;
    logic [15:0] res16;
    logic [15:0] cyc8, cyc16;

    logic        m_ops_rdy, m_res_val, m_busy;
    logic [15:0] m_res, m_cyc;

    int n_cmp = 0;
    int n_bad = 0;

    assign ops_val8  = ops_val & ~use16;
    assign ops_val16 = ops_val & use16;
    assign res_rdy8  = res_rdy & ~use16;
    assign res_rdy16 = res_rdy & use16;
    assign m_ops_rdy = use16 ? ops_rdy16 : ops_rdy8;
    assign m_res_val = use16 ? res_val16 : res_val8;
    assign m_busy    = use16 ? busy16 : busy8;
    assign m_res     = use16 ? res16 : {8'h00, res8};
    assign m_cyc     = use16 ? cyc16 : cyc8;

    gcd_iter #(.WL(8), .CW(16)) u_dut8 (
        .clk(clk), .rst_b(rst_b), .ops_val(ops_val8), .ops_rdy(ops_rdy8),
        .op_a(op_a[7:0]), .op_b(op_b[7:0]), .mode(mode_s), .res_val(res_val8),
        .res_rdy(res_rdy8), .res(res8), .res_cycles(cyc8), .busy(busy8)
    );

    gcd_iter #(.WL(16), .CW(16)) u_dut16 (
        .clk(clk), .rst_b(rst_b), .ops_val(ops_val16), .ops_rdy(ops_rdy16),
        .op_a(op_a), .op_b(op_b), .mode(mode_s), .res_val(res_val16),
        .res_rdy(res_rdy16), .res(res16), .res_cycles(cyc16), .busy(busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_gcd(input int x_in, input int y_in);
        int x = x_in;
        int y = y_in;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Full operation: handshake in, wait for result, handshake out. lat counts the capture cycle as 1.
    task automatic run_op(input logic m, input logic [15:0] a, input logic [15:0] b,
                          output int r, output int c, output int lat);
        int t = 0;
        r = -1; c = -1; lat = 0;
        while (!m_ops_rdy && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (!m_ops_rdy) begin
            chk("ops_rdy_timeout", 0, 1);
            return;
        end
        mode_s = m; op_a = a; op_b = b; ops_val = 1'b1;
        @(posedge clk); #1;
        ops_val = 1'b0;
        op_a = 16'($urandom); op_b = 16'($urandom); mode_s = ~m;
        lat = 1;
        while (!m_res_val && lat < 4000) begin
            @(posedge clk); #1; lat++;
        end
        if (!m_res_val) begin
            chk("res_val_timeout", 0, 1);
            return;
        end
        r = int'(m_res);
        c = int'(m_cyc);
        res_rdy = 1'b1;
        @(posedge clk); #1;
        res_rdy = 1'b0;
        chk("post_release_ops_rdy", int'(m_ops_rdy), 1);
        chk("post_release_res_val", int'(m_res_val), 0);
        $display("txn w%0d mode=%0d a=%0d b=%0d -> res=%0d cycles=%0d lat=%0d",
                 use16 ? 16 : 8, m, a, b, r, c, lat);
    endtask

    typedef struct {
        logic       m;
        logic [7:0] a;
        logic [7:0] b;
        int         r;
        int         cyc;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int r, c, lat, r0, r1;
        logic [15:0] ra, rb;

        vecs[0]  = '{1'b0,   6,   4,  2,   6};
        vecs[1]  = '{1'b1,   6,   4,  2,   6};
        vecs[2]  = '{1'b0,   0,   0,  0,   1};
        vecs[3]  = '{1'b1,   0,   0,  0,   1};
        vecs[4]  = '{1'b0,   0,   5,  5,   2};
        vecs[5]  = '{1'b1,   0,   5,  5,   1};
        vecs[6]  = '{1'b0,   5,   0,  5,   1};
        vecs[7]  = '{1'b1,   5,   0,  5,   1};
        vecs[8]  = '{1'b0,  12,  18,  6,   7};
        vecs[9]  = '{1'b1,  12,  18,  6,   6};
        vecs[10] = '{1'b0,   7,   7,  7,   3};
        vecs[11] = '{1'b1,   7,   7,  7,   2};
        vecs[12] = '{1'b0, 255,   1,  1, 257};
        vecs[13] = '{1'b1, 255,   1,  1,  16};
        vecs[14] = '{1'b1, 128,  64, 64,   9};

        use16 = 1'b0; ops_val = 1'b0; res_rdy = 1'b0; mode_s = 1'b0;
        op_a = '0; op_b = '0;
        rst_b = 1'b1;
        #1 rst_b = 1'b0;
        #2;
        chk("rst_ops_rdy8", int'(ops_rdy8), 1);
        chk("rst_res_val8", int'(res_val8), 0);
        chk("rst_busy8", int'(busy8), 0);
        chk("rst_res8", int'(res8), 0);
        chk("rst_cyc8", int'(cyc8), 0);
        chk("rst_ops_rdy16", int'(ops_rdy16), 1);
        chk("rst_busy16", int'(busy16), 0);
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].m, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, r, c, lat);
            chk($sformatf("vec%0d_res", i), r, vecs[i].r);
            chk($sformatf("vec%0d_cycles", i), c, vecs[i].cyc);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].cyc + 1);
        end

        // Backpressure: result must hold and new operands must be refused.
        run_op(1'b0, 16'd6, 16'd4, r, c, lat);
        mode_s = 1'b0; op_a = 16'd6; op_b = 16'd4; ops_val = 1'b1;
        @(posedge clk); #1;
        ops_val = 1'b0;
        begin
            int t = 0;
            while (!res_val8 && t < 50) begin
                @(posedge clk); #1; t++;
            end
        end
        ops_val = 1'b1; op_a = 16'd9; op_b = 16'd3; mode_s = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_res_val", i), int'(res_val8), 1);
            chk($sformatf("bp%0d_res", i), int'(res8), 2);
            chk($sformatf("bp%0d_cycles", i), int'(cyc8), 6);
            chk($sformatf("bp%0d_ops_rdy", i), int'(ops_rdy8), 0);
            @(posedge clk); #1;
        end
        ops_val = 1'b0;
        res_rdy = 1'b1;
        @(posedge clk); #1;
        res_rdy = 1'b0;
        chk("bp_idle_ops_rdy", int'(ops_rdy8), 1);
        chk("bp_idle_busy", int'(busy8), 0);
        chk("bp_idle_res_held", int'(res8), 2);
        $display("txn w8 backpressure 5 cycles -> res=%0d cycles=%0d", res8, cyc8);

        // Reset pulse in the middle of a long Euclid run.
        mode_s = 1'b0; op_a = 16'd200; op_b = 16'd3; ops_val = 1'b1;
        @(posedge clk); #1;
        ops_val = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("calc_busy", int'(busy8), 1);
        chk("calc_res_held", int'(res8), 2);
        chk("calc_cyc_held", int'(cyc8), 6);
        rst_b = 1'b0;
        #1;
        chk("midrst_busy", int'(busy8), 0);
        chk("midrst_ops_rdy", int'(ops_rdy8), 1);
        chk("midrst_res_val", int'(res_val8), 0);
        chk("midrst_res", int'(res8), 0);
        chk("midrst_cyc", int'(cyc8), 0);
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        @(posedge clk); #1;
        chk("postrst_idle", int'(ops_rdy8), 1);
        chk("postrst_res_val", int'(res_val8), 0);
        $display("txn w8 reset during CALC of 200,3");
        run_op(1'b1, 16'd12, 16'd18, r, c, lat);
        chk("postrst_res", r, 6);

        // 16-bit sweep: both modes against a modulo-based reference.
        use16 = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(256, 65535));
            if ($urandom_range(0, 1) == 1) begin
                logic [15:0] tmp;
                tmp = ra; ra = rb; rb = tmp;
            end
            run_op(1'b0, ra, rb, r0, c, lat);
            run_op(1'b1, ra, rb, r1, c, lat);
            chk($sformatf("rnd%0d_euclid", i), r0, ref_gcd(int'(ra), int'(rb)));
            chk($sformatf("rnd%0d_binary", i), r1, ref_gcd(int'(ra), int'(rb)));
            chk($sformatf("rnd%0d_agree", i), r1, r0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
